// File: rtl/conv_encoder_stream.sv
// conv_encoder_stream
// Streaming rate-1/N convolutional encoder with runtime N, K, generator
// polynomials and frame length. Each frame is zero-terminated with K-1
// flush bits. Input and output use valid/ready handshakes through a single
// output register, so one symbol per cycle is sustained.
// Optional feature macro: CONV_PUNCTURE_EN adds a two-column puncturing
// mask that drives o_sym_mask.
module conv_encoder_stream #(
    parameter int MAX_K     = 9,
    parameter int MAX_N     = 3,
    parameter int MAX_FRAME = 128,
    parameter int LW        = $clog2(MAX_FRAME + 1)
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   i_start,
    input  logic [1:0]             i_code_n,
    input  logic [3:0]             i_constr_len,
    input  logic [MAX_K*MAX_N-1:0] i_gen_poly_flat,
    input  logic [LW-1:0]          i_frame_len,
    input  logic                   i_bit_valid,
    input  logic                   i_bit,
    output logic                   o_bit_ready,
    output logic                   o_sym_valid,
    output logic [MAX_N-1:0]       o_sym,
    output logic [MAX_N-1:0]       o_sym_mask,
    output logic                   o_sym_last,
    input  logic                   i_sym_ready,
`ifdef CONV_PUNCTURE_EN
    input  logic                   i_punct_en,
    input  logic [2*MAX_N-1:0]     i_punct_pat,
`endif
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0]    N_MAX = 2'(MAX_N);
    localparam logic [3:0]    K_MAX = 4'(MAX_K);
    localparam logic [LW-1:0] F_MAX = LW'(MAX_FRAME);

    // Frame state and latched configuration
    logic [1:0]             r_state;
    logic [MAX_K-2:0]       r_sr;
    logic [1:0]             r_n;
    logic [3:0]             r_k;
    logic [MAX_K*MAX_N-1:0] r_poly;
    logic [LW-1:0]          r_last_bit;
    logic [LW-1:0]          r_bit_cnt;
    logic [3:0]             r_flush_last;
    logic [3:0]             r_flush_cnt;
    logic                   r_done;

    // Output register
    logic                   r_sym_valid;
    logic [MAX_N-1:0]       r_sym;
    logic [MAX_N-1:0]       r_sym_mask;
    logic                   r_sym_last;

`ifdef CONV_PUNCTURE_EN
    logic                   r_punct_en;
    logic [2*MAX_N-1:0]     r_punct_pat;
    logic                   r_col;
`endif

    logic [1:0]             w_n_dec;
    logic [3:0]             w_k_dec;
    logic [LW-1:0]          w_len_dec;
    logic                   w_room;
    logic                   w_adv;
    logic                   w_pop;
    logic                   w_in;
    logic                   w_last_in;
    logic [MAX_K-1:0]       w_win;
    logic [MAX_K-1:0]       w_kmask;
    logic [MAX_N-1:0]       w_nmask;
    logic [MAX_N-1:0]       w_code;
    logic [MAX_N-1:0]       w_mask;

    // Clamp the configuration inputs into their legal ranges before latching
    assign w_n_dec   = (i_code_n >= 2'd2 && i_code_n <= N_MAX) ? i_code_n : 2'd2;
    assign w_k_dec   = (i_constr_len >= 4'd3 && i_constr_len <= K_MAX) ? i_constr_len : K_MAX;
    assign w_len_dec = (i_frame_len == '0)   ? LW'(1) :
                       (i_frame_len > F_MAX) ? F_MAX  : i_frame_len;

    // The output register can take a new symbol when empty or being drained this cycle
    assign w_room      = !r_sym_valid || i_sym_ready;
    assign w_adv       = en && w_room &&
                         (((r_state == ST_ENCODE) && i_bit_valid) || (r_state == ST_FLUSH));
    assign w_pop       = en && r_sym_valid && i_sym_ready;
    assign o_bit_ready = en && (r_state == ST_ENCODE) && w_room;

    // Flush phase shifts in zeros; w[0] is the current bit, w[j] the bit j steps ago
    assign w_in      = (r_state == ST_ENCODE) ? i_bit : 1'b0;
    assign w_win     = {r_sr, w_in};
    assign w_last_in = (r_state == ST_FLUSH) && (r_flush_cnt == r_flush_last);

    // Tap masks: only the lower K window bits and lower N outputs take part
    always_comb begin
        for (int j = 0; j < MAX_K; j++) begin
            w_kmask[j] = (4'(j) < r_k);
        end
        for (int i = 0; i < MAX_N; i++) begin
            w_nmask[i] = (2'(i) < r_n);
        end
    end

    // Each code bit is the parity of its generator taps over the window
    always_comb begin
        for (int i = 0; i < MAX_N; i++) begin
            w_code[i] = w_nmask[i] & (^(r_poly[i*MAX_K +: MAX_K] & w_win & w_kmask));
        end
    end

`ifdef CONV_PUNCTURE_EN
    // Puncturing column alternates per emitted symbol; still limited to the N live bits
    assign w_mask = r_punct_en ?
                    ((r_col ? r_punct_pat[2*MAX_N-1:MAX_N] : r_punct_pat[MAX_N-1:0]) & w_nmask) :
                    w_nmask;
`else
    assign w_mask = w_nmask;
`endif

    // Frame FSM, shift register and output register; en=0 freezes everything
    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_n          <= 2'd2;
            r_k          <= 4'd3;
            r_poly       <= '0;
            r_last_bit   <= '0;
            r_bit_cnt    <= '0;
            r_flush_last <= '0;
            r_flush_cnt  <= '0;
            r_done       <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_sym        <= '0;
            r_sym_mask   <= '0;
            r_sym_last   <= 1'b0;
`ifdef CONV_PUNCTURE_EN
            r_punct_en   <= 1'b0;
            r_punct_pat  <= '0;
            r_col        <= 1'b0;
`endif
        end else if (en) begin
            r_done <= 1'b0;

            if (w_adv) begin
                r_sym_valid <= 1'b1;
                r_sym       <= w_code;
                r_sym_mask  <= w_mask;
                r_sym_last  <= w_last_in;
                r_sr        <= {r_sr[MAX_K-3:0], w_in};
`ifdef CONV_PUNCTURE_EN
                r_col       <= ~r_col;
`endif
            end else if (w_pop) begin
                r_sym_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_n          <= w_n_dec;
                        r_k          <= w_k_dec;
                        r_poly       <= i_gen_poly_flat;
                        r_last_bit   <= w_len_dec - LW'(1);
                        r_flush_last <= w_k_dec - 4'd2;
                        r_bit_cnt    <= '0;
                        r_flush_cnt  <= '0;
                        r_sr         <= '0;
`ifdef CONV_PUNCTURE_EN
                        r_punct_en   <= i_punct_en;
                        r_punct_pat  <= i_punct_pat;
                        r_col        <= 1'b0;
`endif
                        r_state      <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (w_adv) begin
                        r_bit_cnt <= r_bit_cnt + LW'(1);
                        if (r_bit_cnt == r_last_bit) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_adv) begin
                        r_flush_cnt <= r_flush_cnt + 4'd1;
                        if (w_last_in) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    // Only the final symbol is left in the output register
                    if (w_pop) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_sym_valid = r_sym_valid;
    assign o_sym       = r_sym;
    assign o_sym_mask  = r_sym_mask;
    assign o_sym_last  = r_sym_last;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed testbench for conv_encoder_stream: hand-computed K=3 frames,
// backpressure, a long K=9 frame against a tap-sum model, mid-frame reset,
// ignored restart, zero frame length and (with CONV_PUNCTURE_EN) puncturing.
module tb_conv_encoder_stream;

    localparam int MAX_K     = 9;
    localparam int MAX_N     = 3;
    localparam int MAX_FRAME = 128;
    localparam int LW        = $clog2(MAX_FRAME + 1);

    logic                   sys_clk;
    logic                   rst;
    logic                   en;
    logic                   i_start;
    logic [1:0]             i_code_n;
    logic [3:0]             i_constr_len;
    logic [MAX_K*MAX_N-1:0] i_gen_poly_flat;
    logic [LW-1:0]          i_frame_len;
    logic                   i_bit_valid;
    logic                   i_bit;
    logic                   o_bit_ready;
    logic                   o_sym_valid;
    logic [MAX_N-1:0]       o_sym;
    logic [MAX_N-1:0]       o_sym_mask;
    logic                   o_sym_last;
    logic                   i_sym_ready;
    logic                   o_busy;
    logic                   o_done;
`ifdef CONV_PUNCTURE_EN
    logic                   i_punct_en;
    logic [2*MAX_N-1:0]     i_punct_pat;
`endif

    conv_encoder_stream #(
        .MAX_K(MAX_K), .MAX_N(MAX_N), .MAX_FRAME(MAX_FRAME), .LW(LW)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .en             (en),
        .i_start        (i_start),
        .i_code_n       (i_code_n),
        .i_constr_len   (i_constr_len),
        .i_gen_poly_flat(i_gen_poly_flat),
        .i_frame_len    (i_frame_len),
        .i_bit_valid    (i_bit_valid),
        .i_bit          (i_bit),
        .o_bit_ready    (o_bit_ready),
        .o_sym_valid    (o_sym_valid),
        .o_sym          (o_sym),
        .o_sym_mask     (o_sym_mask),
        .o_sym_last     (o_sym_last),
        .i_sym_ready    (i_sym_ready),
`ifdef CONV_PUNCTURE_EN
        .i_punct_en     (i_punct_en),
        .i_punct_pat    (i_punct_pat),
`endif
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // {g2, g1, g0}; K=3 set carries junk above bit 2 and in the unused g2
    localparam logic [26:0] POLY_K3 = {9'b111111111, 9'b000000101, 9'b110000111};
    // 557/663/711 octal, bit-reversed so bit 0 taps the current input
    localparam logic [26:0] POLY_K9 = {9'b100100111, 9'b110011011, 9'b111101101};

    logic       tx_bits [0:MAX_FRAME-1];
    int         tx_len;
    logic [2:0] exp_sym [0:255];
    logic [2:0] rx_sym  [$];
    logic [2:0] rx_mask [$];
    logic       rx_last [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits 1,0,1,1 with N=2, K=3, g0=111, g1=101 (hand-derived symbols)
    task automatic load_frame1();
        tx_len     = 4;
        tx_bits[0] = 1'b1; tx_bits[1] = 1'b0; tx_bits[2] = 1'b1; tx_bits[3] = 1'b1;
        exp_sym[0] = 3'b011; exp_sym[1] = 3'b001; exp_sym[2] = 3'b000;
        exp_sym[3] = 3'b010; exp_sym[4] = 3'b010; exp_sym[5] = 3'b011;
    endtask

    task automatic start_frame(input logic [1:0] n, input logic [3:0] k,
                               input logic [26:0] polys, input logic [LW-1:0] len);
        @(negedge sys_clk);
        i_code_n        = n;
        i_constr_len    = k;
        i_gen_poly_flat = polys;
        i_frame_len     = len;
        i_start         = 1'b1;
        @(negedge sys_clk);
        i_start         = 1'b0;
    endtask

    // Feeds tx_bits, collects handshaken symbols, checks stall behaviour,
    // o_busy and the o_done pulse every cycle until the frame completes
    task automatic run_stream(input bit toggle_ready, input string tag);
        int         bi = 0;
        int         cyc = 0;
        bit         stalled = 0;
        bit         done_next = 0;
        bit         done_seen = 0;
        logic [2:0] held = '0;
        rx_sym.delete(); rx_mask.delete(); rx_last.delete();
        while (!done_seen && cyc < 2000) begin
            i_sym_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            i_bit_valid = (bi < tx_len);
            i_bit       = (bi < tx_len) ? tx_bits[bi] : 1'b0;
            #1;
            if (stalled) begin
                check({tag, " stall valid"}, 32'(o_sym_valid), 32'd1);
                check({tag, " stall sym"}, 32'(o_sym), 32'(held));
            end
            check({tag, " o_done"}, 32'(o_done), 32'(done_next));
            check({tag, " o_busy"}, 32'(o_busy), 32'(!done_next));
            if (done_next) done_seen = 1;
            done_next = 0;
            stalled   = 0;
            if (o_sym_valid && i_sym_ready) begin
                rx_sym.push_back(o_sym);
                rx_mask.push_back(o_sym_mask);
                rx_last.push_back(o_sym_last);
                if (o_sym_last) done_next = 1;
            end else if (o_sym_valid) begin
                check({tag, " no accept when full"}, 32'(o_bit_ready), 32'd0);
                stalled = 1;
                held    = o_sym;
            end
            if (i_bit_valid && o_bit_ready) bi++;
            if (!done_seen) begin
                @(negedge sys_clk);
                cyc++;
            end
        end
        if (!done_seen) check({tag, " timeout"}, 32'd0, 32'd1);
        i_bit_valid = 1'b0;
        i_sym_ready = 1'b1;
    endtask

    task automatic verify(input string tag, input int nexp,
                          input logic [2:0] m_even, input logic [2:0] m_odd);
        check({tag, " count"}, 32'(rx_sym.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < rx_sym.size(); i++) begin
            check($sformatf("%s sym%0d", tag, i), 32'(rx_sym[i]), 32'(exp_sym[i]));
            check($sformatf("%s mask%0d", tag, i), 32'(rx_mask[i]),
                  32'((i % 2 == 0) ? m_even : m_odd));
            check($sformatf("%s last%0d", tag, i), 32'(rx_last[i]), 32'(i == nexp - 1));
        end
    endtask

    // Reference: c_i(s) = XOR_j g_i[j] * bit[s-j], bits outside the frame are 0
    task automatic model(input int n, input int k, input logic [26:0] polys);
        for (int s = 0; s < tx_len + k - 1; s++) begin
            exp_sym[s] = '0;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < k; j++) begin
                    if (s - j >= 0 && s - j < tx_len)
                        exp_sym[s][i] = exp_sym[s][i] ^ (polys[i*9 + j] & tx_bits[s - j]);
                end
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        en              = 1'b1;
        i_start         = 1'b0;
        i_code_n        = 2'd2;
        i_constr_len    = 4'd3;
        i_gen_poly_flat = '0;
        i_frame_len     = '0;
        i_bit_valid     = 1'b0;
        i_bit           = 1'b0;
        i_sym_ready     = 1'b1;
`ifdef CONV_PUNCTURE_EN
        i_punct_en      = 1'b0;
        i_punct_pat     = '0;
`endif

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst o_sym_valid", 32'(o_sym_valid), 32'd0);
        check("rst o_sym", 32'(o_sym), 32'd0);
        check("rst o_sym_mask", 32'(o_sym_mask), 32'd0);
        check("rst o_sym_last", 32'(o_sym_last), 32'd0);
        check("rst o_bit_ready", 32'(o_bit_ready), 32'd0);
        check("rst o_busy", 32'(o_busy), 32'd0);
        check("rst o_done", 32'(o_done), 32'd0);
        rst = 1'b0;

        // Frame 1, downstream always ready
        load_frame1();
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        run_stream(1'b0, "f1");
        verify("f1", 6, 3'b011, 3'b011);

        // Same frame with downstream ready toggling
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        run_stream(1'b1, "f1bp");
        verify("f1bp", 6, 3'b011, 3'b011);

        // N=3, K=9, 128 random bits
        tx_len = 128;
        for (int i = 0; i < 128; i++) tx_bits[i] = 1'($urandom() & 1);
        model(3, 9, POLY_K9);
        start_frame(2'd3, 4'd9, POLY_K9, LW'(128));
        run_stream(1'b0, "k9");
        verify("k9", 136, 3'b111, 3'b111);

        // Reset while the third symbol is presented
        load_frame1();
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        begin
            int bi = 0;
            int nsym = 0;
            for (int c = 0; c < 20; c++) begin
                i_bit_valid = (bi < tx_len);
                i_bit       = (bi < tx_len) ? tx_bits[bi] : 1'b0;
                #1;
                if (o_sym_valid && nsym == 2) break;
                if (o_sym_valid && i_sym_ready) nsym++;
                if (i_bit_valid && o_bit_ready) bi++;
                @(negedge sys_clk);
            end
            check("pre-rst third symbol valid", 32'(o_sym_valid), 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        check("mid rst o_sym_valid", 32'(o_sym_valid), 32'd0);
        check("mid rst o_sym", 32'(o_sym), 32'd0);
        check("mid rst o_sym_last", 32'(o_sym_last), 32'd0);
        check("mid rst o_bit_ready", 32'(o_bit_ready), 32'd0);
        check("mid rst o_busy", 32'(o_busy), 32'd0);
        i_bit_valid = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        run_stream(1'b0, "post-rst");
        verify("post-rst", 6, 3'b011, 3'b011);

        // Restart during ENCODE is ignored; en=0 blocks the bit handshake
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        i_code_n     = 2'd3;
        i_constr_len = 4'd5;
        i_frame_len  = '0;
        i_start      = 1'b1;
        @(negedge sys_clk);
        i_start     = 1'b0;
        en          = 1'b0;
        i_bit_valid = 1'b1;
        i_bit       = 1'b1;
        #1;
        check("en0 o_bit_ready", 32'(o_bit_ready), 32'd0);
        @(negedge sys_clk);
        check("en0 o_sym_valid held", 32'(o_sym_valid), 32'd0);
        check("en0 o_busy held", 32'(o_busy), 32'd1);
        en          = 1'b1;
        i_bit_valid = 1'b0;
        run_stream(1'b0, "restart");
        verify("restart", 6, 3'b011, 3'b011);

        // Zero frame length encodes one bit plus K-1 flush bits
        tx_len     = 1;
        tx_bits[0] = 1'b1;
        exp_sym[0] = 3'b011; exp_sym[1] = 3'b001; exp_sym[2] = 3'b011;
        start_frame(2'd2, 4'd3, POLY_K3, '0);
        run_stream(1'b0, "len0");
        verify("len0", 3, 3'b011, 3'b011);

`ifdef CONV_PUNCTURE_EN
        // Rate 2/3 puncturing: column 0 = 11, column 1 = 01
        load_frame1();
        i_punct_en  = 1'b1;
        i_punct_pat = {3'b001, 3'b011};
        start_frame(2'd2, 4'd3, POLY_K3, LW'(4));
        i_punct_en  = 1'b0;
        run_stream(1'b0, "punct");
        verify("punct", 6, 3'b011, 3'b001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_encoder_stream.md
Name: conv_encoder_stream

Overview:
Parametrised streaming convolutional encoder, successor to the fixed-frame encoder inside endec_interface.
- Accepts one info bit per handshake; emits one N-bit code symbol per bit; zero-terminates every frame with K-1 flush bits.
- Runtime code rate 1/N (N = 2..MAX_N), constraint length K (3..MAX_K), generator polynomials and frame length.
- Sits between the frame buffer and the Viterbi decoder/channel model; valid/ready on both sides.

Parameters:
MAX_K, 9, maximum constraint length
MAX_N, 3, maximum code outputs per input bit
MAX_FRAME, 128, maximum info bits per frame
LW, $clog2(MAX_FRAME+1), frame-length field width

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  global enable; 0 freezes all state, outputs held
i_start  in  1  one-cycle pulse; latches config and starts a frame
i_code_n  in  2  N, 2 or 3 (other values treated as 2)
i_constr_len  in  4  K, 3..MAX_K (out of range clamped to MAX_K)
i_gen_poly_flat  in  MAX_K*MAX_N  polynomial g_i in bits [i*MAX_K +: MAX_K]; bit 0 taps current input
i_frame_len  in  LW  info bits in frame, 1..MAX_FRAME (0 treated as 1)
i_bit_valid  in  1  input bit valid
i_bit  in  1  info bit
o_bit_ready  out  1  encoder accepts bit
o_sym_valid  out  1  code symbol valid
o_sym  out  MAX_N  code symbol {c_{N-1}..c0}; unused upper bits 0
o_sym_mask  out  MAX_N  which o_sym bits are transmitted
o_sym_last  out  1  marks final symbol of frame
i_sym_ready  in  1  downstream accepts symbol
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse after last symbol accepted

Behaviour:
- Reset: state IDLE, shift register 0, counters 0, all outputs 0.
- Config latched on i_start in IDLE only; i_start ignored outside IDLE.
- Window w = {sr[MAX_K-2:0], in}; w[j] = input j bits ago. c_i = XOR of (g_i[K-1:0] & w[K-1:0]); polynomial bits >= K ignored; c_i = 0 for i >= N.
- FSM: IDLE -(i_start)-> ENCODE -(frame_len bits accepted)-> FLUSH -(K-1 zero bits encoded)-> DRAIN -(output register empty)-> IDLE with o_done pulse.
- Single output register (skid-free): o_bit_ready = (state==ENCODE) && (!o_sym_valid || i_sym_ready). Bit accepted on i_bit_valid && o_bit_ready; symbol registered the same edge, o_sym_valid next cycle. Latency 1 cycle bit-to-symbol.
- FLUSH: feeds zero internally at the same rate, subject to the same output backpressure.
- o_sym_valid holds, with o_sym stable, until i_sym_ready. Symbol accept and new bit in the same cycle allowed (full throughput 1 symbol/cycle).
- o_sym_last = 1 on the (frame_len+K-2)th symbol, counting from 0. Total symbols = frame_len + K - 1.
- o_busy = 1 from the cycle after i_start until o_done. o_done lasts one cycle, at the edge where the last symbol handshakes.
- Shift register cleared on entering ENCODE, so every frame starts from state 0.
- rst mid-frame: immediate return to IDLE; partial frame discarded; o_sym_valid drops asynchronously.
- en=0: no state change, handshakes not honoured (o_bit_ready forced 0, o_sym_valid held).
- o_sym_mask = lower-N ones when puncturing is absent or disabled.

Optional Feature:
CONV_PUNCTURE_EN. When defined: extra ports i_punct_en (1) and i_punct_pat (2*MAX_N, two column masks, column 0 in bits [MAX_N-1:0]), latched on i_start. With i_punct_en=1, o_sym_mask = pattern column (symbol index mod 2), ANDed with lower-N ones; o_sym is still full; column toggles per emitted symbol, including flush; the column resets to 0 per frame. Undefined: ports absent, mask always lower-N ones.

Test Plan:
- N=2, K=3, g0=111, g1=101, frame_len=4, bits 1,0,1,1, i_sym_ready=1 -> o_sym[1:0] = 11,01,00,10,10,11; last flag on 6th; o_done one cycle after.
- Same frame, i_sym_ready toggling 1/0 -> identical symbol sequence; o_sym stable while stalled; no bit accepted while output full and not ready.
- N=3, K=9, polys 557/663/711 octal (bit-reversed), frame_len=128 random -> 136 symbols matching reference model; o_sym_last on index 135.
- rst asserted during 3rd symbol of the frame -> all outputs 0; a new i_start then produces a clean frame from state 0.
- i_start during ENCODE, and i_frame_len=0 -> start ignored; zero length encodes 1 bit + K-1 flush.
- CONV_PUNCTURE_EN, N=2, pattern col0=11, col1=01 (rate 2/3) -> masks alternate 11,01 across all 6 symbols of the first test.
